// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer and the ALU it borrows.
// Holds ALU op codes, MDU op encodings and the sequencer state type.
package mdu_seq_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;

  typedef enum logic [1:0] {
    MDU_MUL   = 2'b00,
    MDU_MULHU = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_REMU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_t;

  // DIVU and REMU share the top encoding bit
  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU shared by the execute stage and the MDU sequencer.
// cout is the ADD carry, or for SUB the no-borrow flag (a >= b unsigned).
module alu
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH:0] sum_add;
  logic [WIDTH:0] sum_sub;

  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result = '0;
    cout   = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        result = sum_add[WIDTH-1:0];
        cout   = sum_add[WIDTH];
      end
      ALU_SUB: begin
        result = sum_sub[WIDTH-1:0];
        cout   = sum_sub[WIDTH];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU using one borrowed ALU operation per cycle.
// acc_reg is hi (multiply) or rem (divide); sh_reg is lo (multiply) or quo (divide).
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout
);

  mdu_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             dz_reg, dz_next;
  logic [WIDTH:0]   div_s;
  logic             div_ge;

  assign div_s = {acc_reg, sh_reg[WIDTH-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      opb_reg    <= '0;
      acc_reg    <= '0;
      sh_reg     <= '0;
      result_reg <= '0;
      dz_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      opb_reg    <= opb_next;
      acc_reg    <= acc_next;
      sh_reg     <= sh_next;
      result_reg <= result_next;
      dz_reg     <= dz_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    opb_next    = opb_reg;
    acc_next    = acc_reg;
    sh_next     = sh_reg;
    result_next = result_reg;
    dz_next     = dz_reg;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    div_ge      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          op_next  = op;
          opb_next = opb;
          cnt_next = '0;
          acc_next = '0;
          sh_next  = opa;
          dz_next  = 1'b0;
          if (is_div(op) && (opb == '0)) begin
            // Divide by zero short-circuits: no ALU cycles at all
            state_next  = ST_DONE;
            dz_next     = 1'b1;
            result_next = (op == MDU_DIVU) ? '1 : opa;
          end else begin
            state_next = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        cnt_next = cnt_reg + 1'b1;
        if (is_div(op_reg)) begin
          // div_s[WIDTH] set means the shifted remainder already exceeds any divisor
          alu_control = ALU_SUB;
          alu_a       = div_s[WIDTH-1:0];
          alu_b       = opb_reg;
          div_ge      = div_s[WIDTH] | alu_cout;
          acc_next    = div_ge ? alu_result : div_s[WIDTH-1:0];
          sh_next     = {sh_reg[WIDTH-2:0], div_ge};
        end else begin
          alu_control = ALU_ADD;
          alu_a       = acc_reg;
          alu_b       = sh_reg[0] ? opb_reg : '0;
          acc_next    = {alu_cout, alu_result[WIDTH-1:1]};
          sh_next     = {alu_result[0], sh_reg[WIDTH-1:1]};
        end

        if (cnt_reg == CNT_W'(WIDTH-1)) begin
          state_next = ST_DONE;
          case (op_reg)
            MDU_MUL:   result_next = sh_next;
            MDU_MULHU: result_next = acc_next;
            MDU_DIVU:  result_next = sh_next;
            default:   result_next = acc_next;
          endcase
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_DONE);
  assign div_by_zero = (state_reg == ST_DONE) & dz_reg;
  assign result      = result_reg;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq wired to the shared ALU: directed and random ops checked
// against plain 64-bit arithmetic, plus latency, busy, abort and ignore-start behaviour.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;
  logic        alu_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  alu #(.WIDTH(32)) u_alu (
    .a(alu_a), .b(alu_b), .alu_control(alu_control),
    .result(alu_result), .cout(alu_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      MDU_MUL:   return p[31:0];
      MDU_MULHU: return p[63:32];
      MDU_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // One full transaction; poke > 0 pulses a conflicting start in that RUN cycle
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int poke);
    logic [31:0] exp_r;
    logic        exp_dz;
    int          exp_lat, cyc, busy_cnt;
    exp_r   = ref_result(o, a, b);
    exp_dz  = o[1] && (b == 0);
    exp_lat = exp_dz ? 1 : 33;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    #1;
    start = 1'b0; opa = $urandom; opb = $urandom;
    cyc = 0; busy_cnt = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (cyc == 1) begin
        if (exp_dz) begin
          chk("alu_ctl_dz", alu_control, 4'b0000);
        end else if (o[1]) begin
          chk("alu_ctl_div", alu_control, 4'b0001);
          chk("alu_b_div", alu_b, b);
        end else begin
          chk("alu_ctl_mul", alu_control, 4'b0000);
          chk("alu_a_mul", alu_a, 32'd0);
          chk("alu_b_mul", alu_b, a[0] ? b : 32'd0);
        end
      end
      if (poke > 0 && cyc == poke) begin
        start = 1'b1; op = ~o; opa = 32'hDEAD_BEEF; opb = 32'd0;
      end
      if (poke > 0 && cyc == poke + 1) start = 1'b0;
      if (done) break;
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
    chk("result", result, exp_r);
    chk("div_by_zero", div_by_zero, exp_dz);
    $display("op=%0d a=%h b=%h result=%h dz=%0d cycles=%0d", o, a, b, result, div_by_zero, cyc);
    @(negedge clk);
    chk("done_after", done, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("dz_after", div_by_zero, 1'b0);
    chk("result_hold", result, exp_r);
  endtask

  initial begin
    int dones;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_dz", div_by_zero, 1'b0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctl", alu_control, 4'b0000);
    rst = 1'b1;

    do_op(MDU_MUL,   32'd7, 32'd6, 0);
    do_op(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(MDU_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(MDU_DIVU,  32'd100, 32'd7, 0);
    do_op(MDU_REMU,  32'd100, 32'd7, 0);
    do_op(MDU_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 0);
    do_op(MDU_REMU,  32'hFFFF_FFFF, 32'h8000_0001, 0);
    do_op(MDU_DIVU,  32'd5, 32'd0, 0);
    do_op(MDU_REMU,  32'd5, 32'd0, 0);
    do_op(MDU_MULHU, 32'h1234_5678, 32'h9ABC_DEF1, 5);
    do_op(MDU_DIVU,  32'h8765_4321, 32'd3, 5);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 255));
        2: rb = $urandom | 32'h8000_0000;
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, 0);
    end

    // Abort: conflicting start at cycle 5, reset at cycle 10 of a MUL
    @(negedge clk);
    start = 1'b1; op = MDU_MUL; opa = 32'h1234_5678; opb = 32'h9ABC_DEF1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = MDU_DIVU; opb = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("ignore_busy", busy, 1'b1);
    chk("ignore_done", done, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_alu_ctl", alu_control, 4'b0000);
    chk("abort_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_idle", busy, 1'b0);
    do_op(MDU_MUL, 32'd3, 32'd3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative unsigned multiply/divide sequencer that time-shares the existing 32-bit combinational ALU.
- Drives the ALU's a/b/alu_control inputs and consumes its result and cout, one ALU operation per cycle.
- Sits beside the ALU in the execute stage; the core stalls on busy.
- Provides MUL, MULHU, DIVU, REMU without a dedicated multiplier or divider.

Parameters:
- WIDTH, 32, operand width; only 32 is supported, because it matches the ALU.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  request; accepted only in IDLE.
- op  in  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU (quotient), 11 REMU (remainder).
- opa  in  32  multiplicand / dividend, sampled at accept.
- opb  in  32  multiplier / divisor, sampled at accept.
- busy  out  1  high from the cycle after accept until DONE is left.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  32  selected result; held until the next accept.
- div_by_zero  out  1  valid with done; 1 only for DIVU/REMU with opb = 0.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_control  out  4  to ALU; 0000 = ADD, 0001 = SUB.
- alu_result  in  32  from ALU.
- alu_cout  in  1  from ALU; ADD carry out, SUB 1 = no borrow (a >= b).

Behaviour:
- Reset values: state IDLE; busy 0; done 0; result 0; div_by_zero 0; alu_a 0; alu_b 0; alu_control 0000; counter 0; all internal registers 0.
- Reset asserted mid-operation aborts immediately to IDLE; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start.
- IDLE -> DONE on start with a DIVU/REMU op and opb = 0.
- RUN -> DONE when counter = 31 at the clock edge.
- DONE -> IDLE unconditionally.
- Accept (IDLE and start): latch op and opb; clear counter.
- Multiply accept: hi = 0, lo = opa.
- Divide accept: rem = 0, rem_x = 0, quo = opa.
- start outside IDLE is ignored; no queueing.
- Multiply, RUN step:
  - alu_control = ADD, alu_a = hi, alu_b = lo[0] ? opb_r : 0.
  - Update {c, hi, lo} <= {alu_cout, alu_result, lo} >> 1, where c is the carry into bit 63.
- Divide, RUN step:
  - Shifted value s = {rem, quo[31]} (33 bits).
  - alu_control = SUB, alu_a = s[31:0], alu_b = opb_r.
  - ge = s[32] | alu_cout.
  - rem <= ge ? alu_result : s[31:0].
  - quo <= {quo[30:0], ge}.
  - The s[32] term covers divisors >= 2^31.
- Outside RUN, alu_a, alu_b and alu_control are 0.
- Counter increments each RUN cycle: 32 RUN cycles, then DONE.
- Timing: accept at edge T; RUN occupies cycles T+1..T+32; done = 1 in cycle T+33. busy = 1 in cycles T+1..T+33.
- Divide-by-zero timing: DONE in cycle T+1.
  - DIVU returns 0xFFFFFFFF; REMU returns opa.
  - div_by_zero = 1; the ALU is not used.
- result is registered on entry to DONE and holds afterwards.
- done and div_by_zero are high only in DONE.
- All arithmetic is unsigned modulo 2^32; no overflow reporting.

Decomposition:
- Shared package holds:
  - ALU op-code constants: ADD 0000, SUB 0001, plus the remaining ALU op codes.
  - MDU op encodings: MUL, MULHU, DIVU, REMU.
  - State encoding: IDLE, RUN, DONE.
- No sub-module: the FSM, counter and shift registers form a single block.
- The bench instantiates the real ALU and wires it to this block.

Test Plan:
- MUL 7 x 6, start in IDLE -> done exactly 33 cycles after accept, result 42, busy high 33 cycles.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; same operands with MUL -> result 0x00000001.
- DIVU 100 / 7 -> result 14; REMU 100 / 7 -> result 2; div_by_zero = 0.
- DIVU 0xFFFFFFFF / 0x80000001 -> result 1; REMU on the same operands -> 0x7FFFFFFE (exercises s[32]).
- DIVU 5 / 0 -> done 1 cycle after accept, result 0xFFFFFFFF, div_by_zero 1; REMU 5 / 0 -> result 5.
- Abort and busy-ignore sequence:
  - start MUL, pulse start again at cycle 5 -> ignored; result unchanged by the second pulse.
  - assert rst low at cycle 10 -> busy 0, alu_control 0, no done pulse.
  - new MUL 3 x 3 after reset -> result 9.
